rename_regfile_param: RTL and testbench
=======================================

Name: rename_regfile_param

Overview:
Parametrised successor to the single-issue register/rename stage. It holds the architectural GPR values, the NZCV flags and per-register rename tags (ROB indices). It sits between decode and the ROB. Each accepted dispatch reads its sources, renames its destination, and presents one registered operand packet to the ROB. Compared with its predecessor it adds:
- valid/ready backpressure;
- a hard-wired zero register;
- flush recovery;
- ordered same-cycle commit/rename resolution.

Parameters:
GPR_COUNT, 32, number of architectural registers
GPR_W, 64, register/value width in bits
ROB_IDX_W, 4, ROB index (tag) width
IMM_W, 64, immediate width; zero-extended to GPR_W when narrower
ZERO_REG, 31, index that always reads 0/valid and is never renamed

Ports:
in_clk  in  1  clock
in_rst  in  1  synchronous active-high reset
in_d_valid  in  1  decode presents an instruction
out_d_ready  out  1  block can accept this cycle
in_d_src1, in_d_src2, in_d_dst  in  $clog2(GPR_COUNT) each  register indices
in_d_writes_dst  in  1  instruction writes dst
in_d_set_nzcv  in  1  instruction writes flags
in_d_use_imm  in  1  src2 replaced by immediate
in_d_imm  in  IMM_W  immediate
in_rob_next_idx  in  ROB_IDX_W  tag allocated to this dispatch
out_rob_valid  out  1  packet valid
in_rob_ready  in  1  ROB accepts packet
out_rob_src1_valid, out_rob_src2_valid, out_rob_nzcv_valid  out  1 each  operand ready
out_rob_src1_value, out_rob_src2_value  out  GPR_W each  operand value (meaningful when valid)
out_rob_src1_tag, out_rob_src2_tag, out_rob_nzcv_tag  out  ROB_IDX_W each  producer tag (meaningful when not valid)
out_rob_nzcv  out  4  flag value
out_rob_dst  out  $clog2(GPR_COUNT)  destination index
out_rob_set_nzcv  out  1  passthrough
in_commit_valid  in  1  ROB commits one entry
in_commit_reg  in  $clog2(GPR_COUNT)  committed destination
in_commit_tag  in  ROB_IDX_W  committed ROB index
in_commit_value  in  GPR_W  committed value
in_commit_writes_dst, in_commit_set_nzcv  in  1 each  commit writes GPR / flags
in_commit_nzcv  in  4  committed flags
in_flush  in  1  squash all speculative renames

Behaviour:
- Reset: all GPR values 0, valid=1, tags 0; NZCV=0, valid=1, tag 0; out_rob_valid=0; all out_rob_* data outputs 0.
- Handshake: out_d_ready = !out_rob_valid | in_rob_ready, and is forced 0 while in_flush=1. Accept = in_d_valid & out_d_ready. The packet appears on out_rob_* the cycle after accept (1-cycle latency). It stays stable while out_rob_valid & !in_rob_ready.
- out_rob_valid set on accept. Cleared on handshake without a new accept, and on flush.
- Read order: sources are sampled against the state as it stood before this dispatch's own rename. If src equals dst, the read returns the old mapping.
- ZERO_REG source: value 0, valid=1, tag 0.
- use_imm: src2 = zero-extended imm, valid=1, tag 0.
- Rename on accept:
  - If in_d_writes_dst & dst!=ZERO_REG: gpr[dst].valid<=0 and gpr[dst].tag<=in_rob_next_idx.
  - If in_d_set_nzcv: nzcv_valid<=0 and nzcv_tag<=in_rob_next_idx.
- Commit:
  - GPR: if in_commit_valid & in_commit_writes_dst & in_commit_reg!=ZERO_REG, the value is always written (architectural state). valid<=1 only when in_commit_tag == gpr[reg].tag.
  - Flags: same rule using in_commit_set_nzcv, in_commit_nzcv and nzcv_tag.
- Same-cycle commit and rename of the same register: commit writes the value, rename wins valid/tag (valid=0, new tag).
- Flush: all GPR and NZCV valid<=1; tags unchanged; out_rob_valid<=0; no accept that cycle. A commit in the same cycle still writes its value. Flush has priority over rename.
- Reset mid-operation: everything returns to reset values next cycle; in-flight packet dropped.
- Tag wrap-around is owned by the ROB. This block compares tags by equality only.

Optional Feature:
COMMIT_BYPASS_EN
- Defined: a source/NZCV read in the accept cycle whose register matches a same-cycle tag-matching commit returns the commit value with valid=1.
- Undefined: the read sees pre-commit state (valid=0, tag), and the ROB must capture the broadcast.

Test Plan:
- Reset, then dispatch src1=3, src2=4, dst=5, next_idx=2 -> next cycle src1/src2 valid=1 value 0; following dispatch reading r5 returns valid=0, tag=2.
- Dispatch dst=5 tag 2, then dst=5 tag 7, then commit reg5 tag2 value 0xAA -> r5 stays invalid with tag 7; after commit tag7 value 0xBB, a read of r5 returns 0xBB valid.
- Dispatch src1=5, dst=5 with r5 invalid tag 3, next_idx=6 -> src1 tag=3; subsequent read of r5 gives tag 6.
- Hold in_rob_ready=0 for 3 cycles with in_d_valid=1 -> out_d_ready=0 after first accept, packet stable; release -> second packet follows next cycle.
- Rename r1 (tag 4) and NZCV, assert in_flush -> r1 and NZCV read valid=1 with the last committed values; out_rob_valid=0.
- Read ZERO_REG and dispatch dst=ZERO_REG -> value 0 valid; ZERO_REG never invalidated. With COMMIT_BYPASS_EN, a same-cycle commit r2 value 9 while dispatching src1=2 -> src1 valid value 9.

Source files
------------

// File: rtl/rename_regfile_param.sv
// rename_regfile_param
//   Register/rename stage between decode and the ROB. Holds architectural GPR
//   values, NZCV flags and per-register producer tags (ROB indices). Each
//   accepted dispatch reads its sources against pre-rename state, renames its
//   destination and/or flags, and presents one registered operand packet to
//   the ROB (1-cycle latency, held stable under backpressure).
//
//   Optional build macro: COMMIT_BYPASS_EN
//     defined   - a read that hits a same-cycle tag-matching commit returns the
//                 commit value with valid=1.
//     undefined - reads see pre-commit state; the ROB captures the broadcast.
//
//   Ports:
//     in_clk, in_rst              clock, synchronous active-high reset
//     in_d_*, out_d_ready         decode request and ready
//     in_rob_next_idx             tag allocated to the current dispatch
//     out_rob_*, in_rob_ready     registered operand packet to the ROB
//     in_commit_*                 one commit per cycle from the ROB
//     in_flush                    squash all speculative renames
module rename_regfile_param #(
  parameter int GPR_COUNT = 32,
  parameter int GPR_W     = 64,
  parameter int ROB_IDX_W = 4,
  parameter int IMM_W     = 64,
  parameter int ZERO_REG  = 31
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic                         in_d_valid,
  output logic                         out_d_ready,
  input  logic [$clog2(GPR_COUNT)-1:0] in_d_src1,
  input  logic [$clog2(GPR_COUNT)-1:0] in_d_src2,
  input  logic [$clog2(GPR_COUNT)-1:0] in_d_dst,
  input  logic                         in_d_writes_dst,
  input  logic                         in_d_set_nzcv,
  input  logic                         in_d_use_imm,
  input  logic [IMM_W-1:0]             in_d_imm,
  input  logic [ROB_IDX_W-1:0]         in_rob_next_idx,
  output logic                         out_rob_valid,
  input  logic                         in_rob_ready,
  output logic                         out_rob_src1_valid,
  output logic                         out_rob_src2_valid,
  output logic                         out_rob_nzcv_valid,
  output logic [GPR_W-1:0]             out_rob_src1_value,
  output logic [GPR_W-1:0]             out_rob_src2_value,
  output logic [ROB_IDX_W-1:0]         out_rob_src1_tag,
  output logic [ROB_IDX_W-1:0]         out_rob_src2_tag,
  output logic [ROB_IDX_W-1:0]         out_rob_nzcv_tag,
  output logic [3:0]                   out_rob_nzcv,
  output logic [$clog2(GPR_COUNT)-1:0] out_rob_dst,
  output logic                         out_rob_set_nzcv,
  input  logic                         in_commit_valid,
  input  logic [$clog2(GPR_COUNT)-1:0] in_commit_reg,
  input  logic [ROB_IDX_W-1:0]         in_commit_tag,
  input  logic [GPR_W-1:0]             in_commit_value,
  input  logic                         in_commit_writes_dst,
  input  logic                         in_commit_set_nzcv,
  input  logic [3:0]                   in_commit_nzcv,
  input  logic                         in_flush
);

  localparam int REG_W = $clog2(GPR_COUNT);
  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  // Architectural state
  logic [GPR_W-1:0]     gpr_val_q [GPR_COUNT];
  logic                 gpr_vld_q [GPR_COUNT];
  logic [ROB_IDX_W-1:0] gpr_tag_q [GPR_COUNT];
  logic [3:0]           nzcv_q;
  logic                 nzcv_vld_q;
  logic [ROB_IDX_W-1:0] nzcv_tag_q;

  // Output packet registers
  logic                 valid_q;
  logic                 s1_vld_q, s2_vld_q, f_vld_q;
  logic [GPR_W-1:0]     s1_val_q, s2_val_q;
  logic [ROB_IDX_W-1:0] s1_tag_q, s2_tag_q, f_tag_q;
  logic [3:0]           f_val_q;
  logic [REG_W-1:0]     dst_q;
  logic                 set_nzcv_q;

  // Packet next-state (pre-rename reads)
  logic                 s1_vld_d, s2_vld_d, f_vld_d;
  logic [GPR_W-1:0]     s1_val_d, s2_val_d;
  logic [ROB_IDX_W-1:0] s1_tag_d, s2_tag_d, f_tag_d;
  logic [3:0]           f_val_d;

  logic                 accept;
  logic [GPR_W-1:0]     imm_ext;
  logic [GPR_COUNT-1:0] commit_hit;
  logic [GPR_COUNT-1:0] rename_hit;
  logic                 commit_gpr_match;
  logic                 commit_f_hit;
  logic                 commit_f_match;

  assign out_d_ready = (!valid_q | in_rob_ready) & !in_flush;
  assign accept      = in_d_valid & out_d_ready;

  generate
    if (IMM_W >= GPR_W) begin : g_imm_trunc
      assign imm_ext = in_d_imm[GPR_W-1:0];
    end else begin : g_imm_zext
      assign imm_ext = {{(GPR_W-IMM_W){1'b0}}, in_d_imm};
    end
  endgenerate

  // Per-register commit and rename strobes; the zero register never matches.
  genvar gi;
  generate
    for (gi = 0; gi < GPR_COUNT; gi++) begin : g_hit
      assign commit_hit[gi] = in_commit_valid & in_commit_writes_dst &
                              (in_commit_reg == REG_W'(gi)) &
                              (REG_W'(gi) != ZERO_IDX);
      assign rename_hit[gi] = accept & in_d_writes_dst &
                              (in_d_dst == REG_W'(gi)) &
                              (REG_W'(gi) != ZERO_IDX);
    end
  endgenerate

  // Commit only clears the pending state if it is the youngest producer.
  assign commit_gpr_match = in_commit_valid & in_commit_writes_dst &
                            (in_commit_reg != ZERO_IDX) &
                            (in_commit_tag == gpr_tag_q[in_commit_reg]);
  assign commit_f_hit     = in_commit_valid & in_commit_set_nzcv;
  assign commit_f_match   = commit_f_hit & (in_commit_tag == nzcv_tag_q);

  // Source reads against pre-rename state of this same dispatch.
  always_comb begin
    s1_val_d = gpr_val_q[in_d_src1];
    s1_vld_d = gpr_vld_q[in_d_src1];
    s1_tag_d = gpr_tag_q[in_d_src1];
    if (in_d_src1 == ZERO_IDX) begin
      s1_val_d = '0;
      s1_vld_d = 1'b1;
      s1_tag_d = '0;
    end
`ifdef COMMIT_BYPASS_EN
    else if (commit_gpr_match && (in_commit_reg == in_d_src1)) begin
      s1_val_d = in_commit_value;
      s1_vld_d = 1'b1;
    end
`endif

    s2_val_d = gpr_val_q[in_d_src2];
    s2_vld_d = gpr_vld_q[in_d_src2];
    s2_tag_d = gpr_tag_q[in_d_src2];
    if (in_d_use_imm) begin
      s2_val_d = imm_ext;
      s2_vld_d = 1'b1;
      s2_tag_d = '0;
    end else if (in_d_src2 == ZERO_IDX) begin
      s2_val_d = '0;
      s2_vld_d = 1'b1;
      s2_tag_d = '0;
    end
`ifdef COMMIT_BYPASS_EN
    else if (commit_gpr_match && (in_commit_reg == in_d_src2)) begin
      s2_val_d = in_commit_value;
      s2_vld_d = 1'b1;
    end
`endif

    f_val_d = nzcv_q;
    f_vld_d = nzcv_vld_q;
    f_tag_d = nzcv_tag_q;
`ifdef COMMIT_BYPASS_EN
    if (commit_f_match) begin
      f_val_d = in_commit_nzcv;
      f_vld_d = 1'b1;
    end
`endif
  end

  // GPR file. Commit always writes the value; flush beats rename, and rename
  // beats a same-cycle commit for valid/tag.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < GPR_COUNT; i++) begin
        gpr_val_q[i] <= '0;
        gpr_vld_q[i] <= 1'b1;
        gpr_tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < GPR_COUNT; i++) begin
        if (commit_hit[i]) gpr_val_q[i] <= in_commit_value;
        if (in_flush) begin
          gpr_vld_q[i] <= 1'b1;
        end else if (rename_hit[i]) begin
          gpr_vld_q[i] <= 1'b0;
          gpr_tag_q[i] <= in_rob_next_idx;
        end else if (commit_hit[i] && (in_commit_tag == gpr_tag_q[i])) begin
          gpr_vld_q[i] <= 1'b1;
        end
      end
    end
  end

  // Flags follow the same ordering as a GPR.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      nzcv_q     <= '0;
      nzcv_vld_q <= 1'b1;
      nzcv_tag_q <= '0;
    end else begin
      if (commit_f_hit) nzcv_q <= in_commit_nzcv;
      if (in_flush) begin
        nzcv_vld_q <= 1'b1;
      end else if (accept && in_d_set_nzcv) begin
        nzcv_vld_q <= 1'b0;
        nzcv_tag_q <= in_rob_next_idx;
      end else if (commit_f_match) begin
        nzcv_vld_q <= 1'b1;
      end
    end
  end

  // Output packet. Data only loads on accept, so it holds under backpressure.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      valid_q    <= 1'b0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      f_vld_q    <= 1'b0;
      s1_val_q   <= '0;
      s2_val_q   <= '0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
      f_tag_q    <= '0;
      f_val_q    <= '0;
      dst_q      <= '0;
      set_nzcv_q <= 1'b0;
    end else if (in_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      f_vld_q    <= f_vld_d;
      s1_val_q   <= s1_val_d;
      s2_val_q   <= s2_val_d;
      s1_tag_q   <= s1_tag_d;
      s2_tag_q   <= s2_tag_d;
      f_tag_q    <= f_tag_d;
      f_val_q    <= f_val_d;
      dst_q      <= in_d_dst;
      set_nzcv_q <= in_d_set_nzcv;
    end else if (in_rob_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_rob_valid      = valid_q;
  assign out_rob_src1_valid = s1_vld_q;
  assign out_rob_src2_valid = s2_vld_q;
  assign out_rob_nzcv_valid = f_vld_q;
  assign out_rob_src1_value = s1_val_q;
  assign out_rob_src2_value = s2_val_q;
  assign out_rob_src1_tag   = s1_tag_q;
  assign out_rob_src2_tag   = s2_tag_q;
  assign out_rob_nzcv_tag   = f_tag_q;
  assign out_rob_nzcv       = f_val_q;
  assign out_rob_dst        = dst_q;
  assign out_rob_set_nzcv   = set_nzcv_q;

endmodule

// File: tb/tb_rename_regfile_param.sv
module tb_rename_regfile_param;

  logic        in_clk;
  logic        in_rst;
  logic        in_d_valid;
  logic        out_d_ready;
  logic [4:0]  in_d_src1, in_d_src2, in_d_dst;
  logic        in_d_writes_dst, in_d_set_nzcv, in_d_use_imm;
  logic [63:0] in_d_imm;
  logic [3:0]  in_rob_next_idx;
  logic        out_rob_valid;
  logic        in_rob_ready;
  logic        out_rob_src1_valid, out_rob_src2_valid, out_rob_nzcv_valid;
  logic [63:0] out_rob_src1_value, out_rob_src2_value;
  logic [3:0]  out_rob_src1_tag, out_rob_src2_tag, out_rob_nzcv_tag;
  logic [3:0]  out_rob_nzcv;
  logic [4:0]  out_rob_dst;
  logic        out_rob_set_nzcv;
  logic        in_commit_valid;
  logic [4:0]  in_commit_reg;
  logic [3:0]  in_commit_tag;
  logic [63:0] in_commit_value;
  logic        in_commit_writes_dst, in_commit_set_nzcv;
  logic [3:0]  in_commit_nzcv;
  logic        in_flush;

  int total = 0;
  int bad   = 0;

  rename_regfile_param dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_d_valid(in_d_valid), .out_d_ready(out_d_ready),
    .in_d_src1(in_d_src1), .in_d_src2(in_d_src2), .in_d_dst(in_d_dst),
    .in_d_writes_dst(in_d_writes_dst), .in_d_set_nzcv(in_d_set_nzcv),
    .in_d_use_imm(in_d_use_imm), .in_d_imm(in_d_imm),
    .in_rob_next_idx(in_rob_next_idx),
    .out_rob_valid(out_rob_valid), .in_rob_ready(in_rob_ready),
    .out_rob_src1_valid(out_rob_src1_valid), .out_rob_src2_valid(out_rob_src2_valid),
    .out_rob_nzcv_valid(out_rob_nzcv_valid),
    .out_rob_src1_value(out_rob_src1_value), .out_rob_src2_value(out_rob_src2_value),
    .out_rob_src1_tag(out_rob_src1_tag), .out_rob_src2_tag(out_rob_src2_tag),
    .out_rob_nzcv_tag(out_rob_nzcv_tag), .out_rob_nzcv(out_rob_nzcv),
    .out_rob_dst(out_rob_dst), .out_rob_set_nzcv(out_rob_set_nzcv),
    .in_commit_valid(in_commit_valid), .in_commit_reg(in_commit_reg),
    .in_commit_tag(in_commit_tag), .in_commit_value(in_commit_value),
    .in_commit_writes_dst(in_commit_writes_dst), .in_commit_set_nzcv(in_commit_set_nzcv),
    .in_commit_nzcv(in_commit_nzcv), .in_flush(in_flush)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic disp(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] dst,
                      input logic wr, input logic sf, input logic ui,
                      input logic [63:0] imm, input logic [3:0] idx);
    in_d_src1 = s1; in_d_src2 = s2; in_d_dst = dst;
    in_d_writes_dst = wr; in_d_set_nzcv = sf; in_d_use_imm = ui;
    in_d_imm = imm; in_rob_next_idx = idx;
    in_d_valid = 1'b1; in_rob_ready = 1'b1;
    step();
    in_d_valid = 1'b0;
    $display("dispatch s1=%0d s2=%0d dst=%0d wr=%0b sf=%0b imm=%0b idx=%0d", s1, s2, dst, wr, sf, ui, idx);
  endtask

  task automatic set_commit(input logic [4:0] r, input logic [3:0] tag, input logic [63:0] val,
                            input logic wr, input logic sf, input logic [3:0] nz);
    in_commit_valid = 1'b1; in_commit_reg = r; in_commit_tag = tag;
    in_commit_value = val; in_commit_writes_dst = wr; in_commit_set_nzcv = sf;
    in_commit_nzcv = nz;
  endtask

  task automatic clr_commit();
    in_commit_valid = 1'b0; in_commit_writes_dst = 1'b0; in_commit_set_nzcv = 1'b0;
  endtask

  task automatic commit(input logic [4:0] r, input logic [3:0] tag, input logic [63:0] val,
                        input logic wr, input logic sf, input logic [3:0] nz);
    set_commit(r, tag, val, wr, sf, nz);
    in_rob_ready = 1'b1;
    step();
    clr_commit();
    $display("commit reg=%0d tag=%0d val=%0h nzcv=%0h", r, tag, val, nz);
  endtask

  initial begin
    in_rst = 1'b1; in_d_valid = 1'b0; in_d_src1 = '0; in_d_src2 = '0; in_d_dst = '0;
    in_d_writes_dst = 1'b0; in_d_set_nzcv = 1'b0; in_d_use_imm = 1'b0; in_d_imm = '0;
    in_rob_next_idx = '0; in_rob_ready = 1'b1; in_commit_valid = 1'b0; in_commit_reg = '0;
    in_commit_tag = '0; in_commit_value = '0; in_commit_writes_dst = 1'b0;
    in_commit_set_nzcv = 1'b0; in_commit_nzcv = '0; in_flush = 1'b0;
    step(); step();
    in_rst = 1'b0;
    #1;
    chk("rst_valid", 64'(out_rob_valid), 64'd0);
    chk("rst_src1_value", out_rob_src1_value, 64'd0);
    chk("rst_nzcv_valid", 64'(out_rob_nzcv_valid), 64'd0);
    chk("rst_ready", 64'(out_d_ready), 64'd1);

    // Basic dispatch after reset
    disp(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 64'd0, 4'd2);
    chk("d1_valid", 64'(out_rob_valid), 64'd1);
    chk("d1_s1_valid", 64'(out_rob_src1_valid), 64'd1);
    chk("d1_s1_value", out_rob_src1_value, 64'd0);
    chk("d1_s2_valid", 64'(out_rob_src2_valid), 64'd1);
    chk("d1_dst", 64'(out_rob_dst), 64'd5);
    chk("d1_nzcv_valid", 64'(out_rob_nzcv_valid), 64'd1);
    disp(5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 64'd0, 4'd3);
    chk("d2_s1_valid", 64'(out_rob_src1_valid), 64'd0);
    chk("d2_s1_tag", 64'(out_rob_src1_tag), 64'd2);

    // Stale commit must not clear a newer rename
    disp(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 64'd0, 4'd7);
    commit(5'd5, 4'd2, 64'hAA, 1'b1, 1'b0, 4'd0);
    disp(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("stale_s1_valid", 64'(out_rob_src1_valid), 64'd0);
    chk("stale_s1_tag", 64'(out_rob_src1_tag), 64'd7);
    commit(5'd5, 4'd7, 64'hBB, 1'b1, 1'b0, 4'd0);
    disp(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("match_s1_valid", 64'(out_rob_src1_valid), 64'd1);
    chk("match_s1_value", out_rob_src1_value, 64'hBB);

    // src == dst reads the old mapping
    disp(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 64'd0, 4'd3);
    disp(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 64'd0, 4'd6);
    chk("self_s1_valid", 64'(out_rob_src1_valid), 64'd0);
    chk("self_s1_tag", 64'(out_rob_src1_tag), 64'd3);
    disp(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("self_after_tag", 64'(out_rob_src1_tag), 64'd6);

    // Backpressure
    step();
    chk("bp_idle_valid", 64'(out_rob_valid), 64'd0);
    in_rob_ready = 1'b0; in_d_valid = 1'b1;
    in_d_src1 = 5'd0; in_d_src2 = 5'd0; in_d_dst = 5'd8; in_d_writes_dst = 1'b1;
    in_d_set_nzcv = 1'b0; in_d_use_imm = 1'b0; in_rob_next_idx = 4'd9;
    #1;
    chk("bp_ready_first", 64'(out_d_ready), 64'd1);
    step();
    chk("bp_ready_stall", 64'(out_d_ready), 64'd0);
    in_d_src1 = 5'd8; in_d_dst = 5'd9; in_rob_next_idx = 4'd10;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", 64'(out_rob_valid), 64'd1);
      chk("bp_hold_dst", 64'(out_rob_dst), 64'd8);
      $display("stall cycle %0d dst=%0d", i, out_rob_dst);
    end
    in_rob_ready = 1'b1;
    #1;
    chk("bp_ready_release", 64'(out_d_ready), 64'd1);
    step();
    in_d_valid = 1'b0;
    chk("bp_second_dst", 64'(out_rob_dst), 64'd9);
    chk("bp_second_s1_tag", 64'(out_rob_src1_tag), 64'd9);
    chk("bp_second_s1_valid", 64'(out_rob_src1_valid), 64'd0);
    step();
    chk("bp_drain_valid", 64'(out_rob_valid), 64'd0);

    // Flush recovery
    commit(5'd1, 4'd0, 64'h11, 1'b1, 1'b1, 4'hA);
    disp(5'd1, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 64'd0, 4'd4);
    chk("fl_pre_s1_value", out_rob_src1_value, 64'h11);
    chk("fl_pre_nzcv", 64'(out_rob_nzcv), 64'hA);
    chk("fl_set_nzcv", 64'(out_rob_set_nzcv), 64'd1);
    disp(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("fl_ren_s1_tag", 64'(out_rob_src1_tag), 64'd4);
    chk("fl_ren_nzcv_valid", 64'(out_rob_nzcv_valid), 64'd0);
    chk("fl_ren_nzcv_tag", 64'(out_rob_nzcv_tag), 64'd4);
    in_rob_ready = 1'b0; in_flush = 1'b1; in_d_valid = 1'b1;
    in_d_dst = 5'd2; in_d_writes_dst = 1'b1; in_rob_next_idx = 4'd12;
    #1;
    chk("fl_ready", 64'(out_d_ready), 64'd0);
    step();
    in_flush = 1'b0; in_d_valid = 1'b0;
    chk("fl_out_valid", 64'(out_rob_valid), 64'd0);
    disp(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("fl_s1_valid", 64'(out_rob_src1_valid), 64'd1);
    chk("fl_s1_value", out_rob_src1_value, 64'h11);
    chk("fl_s2_valid", 64'(out_rob_src2_valid), 64'd1);
    chk("fl_nzcv_valid", 64'(out_rob_nzcv_valid), 64'd1);
    chk("fl_nzcv", 64'(out_rob_nzcv), 64'hA);

    // Same-cycle commit and rename: rename owns valid/tag
    set_commit(5'd3, 4'd0, 64'h33, 1'b1, 1'b0, 4'd0);
    disp(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 64'd0, 4'd8);
    clr_commit();
    disp(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("cr_s1_valid", 64'(out_rob_src1_valid), 64'd0);
    chk("cr_s1_tag", 64'(out_rob_src1_tag), 64'd8);
    commit(5'd3, 4'd8, 64'h44, 1'b1, 1'b0, 4'd0);
    disp(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("cr_final_value", out_rob_src1_value, 64'h44);

    // Zero register and immediate
    disp(5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 64'd0, 4'd5);
    chk("z_s1_valid", 64'(out_rob_src1_valid), 64'd1);
    chk("z_s1_value", out_rob_src1_value, 64'd0);
    chk("z_s2_valid", 64'(out_rob_src2_valid), 64'd1);
    commit(5'd31, 4'd0, 64'h77, 1'b1, 1'b0, 4'd0);
    disp(5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b1, 64'h1234, 4'd0);
    chk("z_after_valid", 64'(out_rob_src1_valid), 64'd1);
    chk("z_after_value", out_rob_src1_value, 64'd0);
    chk("imm_value", out_rob_src2_value, 64'h1234);
    chk("imm_tag", 64'(out_rob_src2_tag), 64'd0);

    // Same-cycle commit while reading the committed register
    disp(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 64'd0, 4'd11);
    set_commit(5'd2, 4'd11, 64'd9, 1'b1, 1'b0, 4'd0);
    disp(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    clr_commit();
`ifdef COMMIT_BYPASS_EN
    chk("byp_s1_valid", 64'(out_rob_src1_valid), 64'd1);
    chk("byp_s1_value", out_rob_src1_value, 64'd9);
`else
    chk("byp_s1_valid", 64'(out_rob_src1_valid), 64'd0);
    chk("byp_s1_tag", 64'(out_rob_src1_tag), 64'd11);
`endif
    disp(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("byp_after_valid", 64'(out_rob_src1_valid), 64'd1);
    chk("byp_after_value", out_rob_src1_value, 64'd9);

    // Reset mid-operation
    disp(5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 64'd0, 4'd3);
    in_rob_ready = 1'b0; in_rst = 1'b1;
    step();
    in_rst = 1'b0;
    chk("mrst_valid", 64'(out_rob_valid), 64'd0);
    chk("mrst_s1_value", out_rob_src1_value, 64'd0);
    disp(5'd7, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
    chk("mrst_r7_valid", 64'(out_rob_src1_valid), 64'd1);
    chk("mrst_r5_value", out_rob_src2_value, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
